// File: rtl/fpga_mem_pkg.sv
// Shared constants, types and width helpers for the mixed-width dual-port memory.
package fpga_mem_pkg;

    // Winner when both ports write the same byte in the same cycle.
    typedef enum logic [0:0] {
        COLL_S1_WINS = 1'b0,
        COLL_S2_WINS = 1'b1
    } fpga_mem_coll_e;

    localparam fpga_mem_coll_e FPGA_MEM_WW_POLICY = COLL_S1_WINS;
    localparam int             FPGA_MEM_BYTE_W    = 8;

    // Address width for a word depth; a single-word memory still gets one address bit.
    function automatic int fpga_mem_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wide-port data width.
    function automatic int fpga_mem_b_width(input int a_width, input int ratio);
        return a_width * ratio;
    endfunction

    // Number of byte lanes in a data word.
    function automatic int fpga_mem_lanes(input int width);
        return width / FPGA_MEM_BYTE_W;
    endfunction

endpackage

// File: rtl/fpga_mem_read_pipe.sv
// Per-port read return pipeline: carries valid and data from the storage read
// through 1..N register stages. Internal stages hold while disabled; the last
// stage presents each read exactly once, so a stall never stretches readdatavalid.
module fpga_mem_read_pipe #(
    parameter int DATA_W = 128,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out
);

    localparam int LAST = STAGES - 1;

    logic              vld_p    [STAGES];
    logic [DATA_W-1:0] data_p   [STAGES];
    logic              vld_src  [STAGES];
    logic [DATA_W-1:0] data_src [STAGES];

    // Source of each stage: the pipe input for stage 0, the previous stage otherwise.
    always_comb begin
        vld_src[0]  = vld_in;
        data_src[0] = data_in;
        for (int i = 1; i < STAGES; i++) begin
            vld_src[i]  = vld_p[i-1];
            data_src[i] = data_p[i-1];
        end
    end

    // Valid shift: inner stages hold on stall, the output stage pulses once per token.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < LAST; i++) begin
                if (en) begin
                    vld_p[i] <= vld_src[i];
                end
            end
            vld_p[LAST] <= en & vld_src[LAST];
        end
    end

    // Data shift: a stage loads only with a valid token, so the output holds between reads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LAST; i++) begin
            if (en && vld_src[i]) begin
                data_p[i] <= data_src[i];
            end
        end
        if (rst) begin
            data_p[LAST] <= '0;
        end else if (en && vld_src[LAST]) begin
            data_p[LAST] <= data_src[LAST];
        end
    end

    assign vld_out  = vld_p[LAST];
    assign data_out = data_p[LAST];

endmodule

// File: rtl/fpga_mem_mixed_dp.sv
// Mixed-width true dual-port memory. s1 is the narrow Avalon-MM slave, s2 the
// wide one; s2 word j spans s1 words j*B_RATIO.. with the lowest s1 address in
// the LS bits. Cross-port reads in the cycle of a write return old data; when
// both ports write one byte together, the configured winner keeps it.
module fpga_mem_mixed_dp
    import fpga_mem_pkg::*;
#(
    parameter int    A_WIDTH   = 128,
    parameter int    B_RATIO   = 2,
    parameter int    A_DEPTH   = 4096,
    parameter int    OUTREG_A  = 0,
    parameter int    OUTREG_B  = 0,
    parameter string INIT_FILE = ""
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       reset_req,
    input  logic                                       chipselect,
    input  logic                                       read,
    input  logic                                       write,
    input  logic [fpga_mem_aw(A_DEPTH)-1:0]            address,
    input  logic [A_WIDTH/8-1:0]                       byteenable,
    input  logic [A_WIDTH-1:0]                         writedata,
    input  logic                                       clken,
    output logic [A_WIDTH-1:0]                         readdata,
    output logic                                       readdatavalid,
    input  logic                                       chipselect2,
    input  logic                                       read2,
    input  logic                                       write2,
    input  logic [fpga_mem_aw(A_DEPTH/B_RATIO)-1:0]    address2,
    input  logic [A_WIDTH*B_RATIO/8-1:0]               byteenable2,
    input  logic [A_WIDTH*B_RATIO-1:0]                 writedata2,
    input  logic                                       clken2,
    output logic [A_WIDTH*B_RATIO-1:0]                 readdata2,
    output logic                                       readdatavalid2
);

    localparam int AW_A    = fpga_mem_aw(A_DEPTH);
    localparam int AW_B    = fpga_mem_aw(A_DEPTH / B_RATIO);
    localparam int B_WIDTH = fpga_mem_b_width(A_WIDTH, B_RATIO);
    localparam int LANES_A = fpga_mem_lanes(A_WIDTH);
    localparam int LANES_B = fpga_mem_lanes(B_WIDTH);
    localparam int SUB_SH  = AW_A - AW_B;

    // Storage in s1 word order; the wide port addresses B_RATIO consecutive words.
    logic [A_WIDTH-1:0] mem [A_DEPTH];

    logic               en_a, en_b;
    logic               acc_a, acc_b;
    logic               wr_a, wr_b;
    logic               rd_a, rd_b;
    logic [LANES_A-1:0] be_a_eff;
    logic [LANES_B-1:0] be_b_eff;
    logic [A_WIDTH-1:0] rd_word_a;
    logic [B_WIDTH-1:0] rd_word_b;

    // s1 word index of sub-word k within wide word a2.
    function automatic logic [AW_A-1:0] b_index(input logic [AW_B-1:0] a2, input int k);
        return (AW_A'(a2) << SUB_SH) | AW_A'(k);
    endfunction

    // A request is taken only when selected, clock-enabled and no reset of either kind.
    assign en_a  = clken & ~reset_req;
    assign en_b  = clken2 & ~reset_req;
    assign acc_a = chipselect & en_a & ~reset;
    assign acc_b = chipselect2 & en_b & ~reset;
    assign wr_a  = acc_a & write;
    assign wr_b  = acc_b & write2;
    assign rd_a  = acc_a & read & ~write;
    assign rd_b  = acc_b & read2 & ~write2;

    // Same-byte write collision: strip the losing port's lanes so only the winner lands.
    always_comb begin
        be_a_eff = byteenable;
        be_b_eff = byteenable2;
        if (wr_a && wr_b) begin
            for (int k = 0; k < B_RATIO; k++) begin
                if (b_index(address2, k) == address) begin
                    if (FPGA_MEM_WW_POLICY == COLL_S1_WINS) begin
                        be_b_eff[k*LANES_A +: LANES_A] = be_b_eff[k*LANES_A +: LANES_A] & ~byteenable;
                    end else begin
                        be_a_eff = be_a_eff & ~byteenable2[k*LANES_A +: LANES_A];
                    end
                end
            end
        end
    end

    // Read words taken from the array before this edge's writes, giving old-data semantics.
    always_comb begin
        rd_word_b = '0;
        for (int k = 0; k < B_RATIO; k++) begin
            rd_word_b[k*A_WIDTH +: A_WIDTH] = mem[b_index(address2, k)];
        end
    end

    assign rd_word_a = mem[address];

    // Byte-lane writes; s1 is applied after s2 so it also wins by ordering.
    always_ff @(posedge clk) begin
        if (wr_b) begin
            for (int k = 0; k < B_RATIO; k++) begin
                for (int l = 0; l < LANES_A; l++) begin
                    if (be_b_eff[k*LANES_A + l]) begin
                        mem[b_index(address2, k)][l*8 +: 8] <= writedata2[(k*LANES_A + l)*8 +: 8];
                    end
                end
            end
        end
        if (wr_a) begin
            for (int l = 0; l < LANES_A; l++) begin
                if (be_a_eff[l]) begin
                    mem[address][l*8 +: 8] <= writedata[l*8 +: 8];
                end
            end
        end
    end

    fpga_mem_read_pipe #(
        .DATA_W (A_WIDTH),
        .STAGES (1 + OUTREG_A)
    ) u_pipe_a (
        .clk      (clk),
        .rst      (reset),
        .en       (en_a),
        .vld_in   (rd_a),
        .data_in  (rd_word_a),
        .vld_out  (readdatavalid),
        .data_out (readdata)
    );

    fpga_mem_read_pipe #(
        .DATA_W (B_WIDTH),
        .STAGES (1 + OUTREG_B)
    ) u_pipe_b (
        .clk      (clk),
        .rst      (reset),
        .en       (en_b),
        .vld_in   (rd_b),
        .data_in  (rd_word_b),
        .vld_out  (readdatavalid2),
        .data_out (readdata2)
    );

endmodule

// File: tb/tb_fpga_mem_mixed_dp.sv
// Directed bench for fpga_mem_mixed_dp: narrow port latency 1, wide port latency 2.
module tb_fpga_mem_mixed_dp;

    logic         clk;
    logic         reset;
    logic         reset_req;
    logic         chipselect, read, write, clken;
    logic [5:0]   address;
    logic [15:0]  byteenable;
    logic [127:0] writedata;
    logic [127:0] readdata;
    logic         readdatavalid;
    logic         chipselect2, read2, write2, clken2;
    logic [4:0]   address2;
    logic [31:0]  byteenable2;
    logic [255:0] writedata2;
    logic [255:0] readdata2;
    logic         readdatavalid2;

    int n_checks;
    int n_pass;

    localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_0FAA;
    localparam logic [127:0] VA   = 128'hA1A2_A3A4_A5A6_A7A8_A9AA_ABAC_ADAE_AFA0;
    localparam logic [127:0] VB   = 128'hB1B2_B3B4_B5B6_B7B8_B9BA_BBBC_BDBE_BFB0;
    localparam logic [127:0] VC   = 128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF;
    localparam logic [127:0] LO   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] HI   = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam logic [127:0] OLD8 = 128'h0808_0808_0808_0808_0808_0808_0808_0808;
    localparam logic [127:0] NEW8 = 128'h8E8E_8E8E_8E8E_8E8E_8E8E_8E8E_8E8E_8E8E;
    localparam logic [127:0] X9   = 128'h0909_0909_0909_0909_0909_0909_0909_0909;
    localparam logic [255:0] P    = 256'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F_1234_5678_9ABC_DEF0_0FED_CBA9_8765_43FF;

    logic [255:0] exp_w0;
    logic [255:0] exp_w3;
    logic [255:0] exp_w4;
    logic [255:0] exp_w5;

    fpga_mem_mixed_dp #(
        .A_WIDTH   (128),
        .B_RATIO   (2),
        .A_DEPTH   (64),
        .OUTREG_A  (0),
        .OUTREG_B  (1),
        .INIT_FILE ("")
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .reset_req      (reset_req),
        .chipselect     (chipselect),
        .read           (read),
        .write          (write),
        .address        (address),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .clken          (clken),
        .readdata       (readdata),
        .readdatavalid  (readdatavalid),
        .chipselect2    (chipselect2),
        .read2          (read2),
        .write2         (write2),
        .address2       (address2),
        .byteenable2    (byteenable2),
        .writedata2     (writedata2),
        .clken2         (clken2),
        .readdata2      (readdata2),
        .readdatavalid2 (readdatavalid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect  = 1'b0; read  = 1'b0; write  = 1'b0; clken  = 1'b1;
        address     = '0;   byteenable  = '0; writedata  = '0;
        chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0; clken2 = 1'b1;
        address2    = '0;   byteenable2 = '0; writedata2 = '0;
    endtask

    task automatic s1_write(input logic [5:0] a, input logic [127:0] d, input logic [15:0] be);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
        tick();
        chipselect = 1'b0; write = 1'b0; byteenable = '0;
    endtask

    // Issues one narrow read; its data is visible on return (latency 1).
    task automatic s1_read(input logic [5:0] a);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic s2_issue(input logic [4:0] a);
        chipselect2 = 1'b1; read2 = 1'b1; address2 = a;
        tick();
        chipselect2 = 1'b0; read2 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_w0 = {P[255:8], 8'h11};
        exp_w3 = {VC, LO};
        exp_w4 = {X9, NEW8};
        exp_w5 = {VB, VA};
        idle();
        reset_req = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check_val("rst_rdv",  {255'd0, readdatavalid},  256'd0);
        check_val("rst_rd",   {128'd0, readdata},       256'd0);
        check_val("rst_rdv2", {255'd0, readdatavalid2}, 256'd0);
        check_val("rst_rd2",  readdata2,                256'd0);
        reset = 1'b0;

        // Narrow write then read, latency 1, data holds afterwards
        s1_write(6'd5, D1, 16'hFFFF);
        s1_read(6'd5);
        check_val("t1_vld",  {255'd0, readdatavalid}, 256'd1);
        check_val("t1_data", {128'd0, readdata},      {128'd0, D1});
        tick();
        check_val("t1_vld_drop", {255'd0, readdatavalid}, 256'd0);
        check_val("t1_hold",     {128'd0, readdata},      {128'd0, D1});

        // Narrow words seen through the wide port, wide half-word write seen through narrow
        s1_write(6'd10, VA, 16'hFFFF);
        s1_write(6'd11, VB, 16'hFFFF);
        s1_write(6'd7,  VC, 16'hFFFF);
        s2_issue(5'd5);
        check_val("t2_lat", {255'd0, readdatavalid2}, 256'd0);
        tick();
        check_val("t2_vld2", {255'd0, readdatavalid2}, 256'd1);
        check_val("t2_w5",   readdata2,                exp_w5);
        chipselect2 = 1'b1; write2 = 1'b1; address2 = 5'd3;
        writedata2 = {HI, LO}; byteenable2 = 32'h0000_FFFF;
        tick();
        chipselect2 = 1'b0; write2 = 1'b0; byteenable2 = '0;
        s1_read(6'd6);
        check_val("t2_a6", {128'd0, readdata}, {128'd0, LO});
        s1_read(6'd7);
        check_val("t2_a7", {128'd0, readdata}, {128'd0, VC});

        // Narrow write and wide read of the same word in one cycle: old data first
        s1_write(6'd8, OLD8, 16'hFFFF);
        s1_write(6'd9, X9,   16'hFFFF);
        chipselect = 1'b1; write = 1'b1; address = 6'd8; writedata = NEW8; byteenable = 16'hFFFF;
        chipselect2 = 1'b1; read2 = 1'b1; address2 = 5'd4;
        tick();
        idle();
        tick();
        check_val("t3_old", readdata2, {X9, OLD8});
        s2_issue(5'd4);
        tick();
        check_val("t3_new", readdata2, exp_w4);

        // Both ports write byte 0 of narrow word 0: narrow wins, other wide bytes land
        chipselect = 1'b1; write = 1'b1; address = 6'd0;
        writedata = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF11; byteenable = 16'h0001;
        chipselect2 = 1'b1; write2 = 1'b1; address2 = 5'd0;
        writedata2 = {P[255:8], 8'h22}; byteenable2 = 32'hFFFF_FFFF;
        tick();
        idle();
        s1_read(6'd0);
        check_val("t4_a0", {128'd0, readdata}, {128'd0, P[127:8], 8'h11});
        s1_read(6'd1);
        check_val("t4_a1", {128'd0, readdata}, {128'd0, P[255:128]});

        // Wide burst of four with a two-cycle clken2 stall after the second
        chipselect2 = 1'b1; read2 = 1'b1; address2 = 5'd5;
        tick();
        check_val("t5_e0_vld", {255'd0, readdatavalid2}, 256'd0);
        address2 = 5'd3;
        tick();
        check_val("t5_r0_vld", {255'd0, readdatavalid2}, 256'd1);
        check_val("t5_r0",     readdata2,                exp_w5);
        clken2 = 1'b0; address2 = 5'd4;
        tick();
        check_val("t5_st0_vld", {255'd0, readdatavalid2}, 256'd0);
        check_val("t5_st0_hold", readdata2,               exp_w5);
        tick();
        check_val("t5_st1_vld", {255'd0, readdatavalid2}, 256'd0);
        clken2 = 1'b1;
        tick();
        check_val("t5_r1_vld", {255'd0, readdatavalid2}, 256'd1);
        check_val("t5_r1",     readdata2,                exp_w3);
        address2 = 5'd0;
        tick();
        check_val("t5_r2_vld", {255'd0, readdatavalid2}, 256'd1);
        check_val("t5_r2",     readdata2,                exp_w4);
        chipselect2 = 1'b0; read2 = 1'b0;
        tick();
        check_val("t5_r3_vld", {255'd0, readdatavalid2}, 256'd1);
        check_val("t5_r3",     readdata2,                exp_w0);
        tick();
        check_val("t5_end_vld", {255'd0, readdatavalid2}, 256'd0);

        // Narrow write with no lanes enabled changes nothing
        s1_write(6'd5, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 16'h0000);
        s1_read(6'd5);
        check_val("be0_data", {128'd0, readdata}, {128'd0, D1});

        // reset_req freezes an in-flight wide read; it completes after release
        s2_issue(5'd3);
        reset_req = 1'b1;
        tick();
        check_val("rq_frz0", {255'd0, readdatavalid2}, 256'd0);
        tick();
        check_val("rq_frz1", {255'd0, readdatavalid2}, 256'd0);
        reset_req = 1'b0;
        tick();
        check_val("rq_vld",  {255'd0, readdatavalid2}, 256'd1);
        check_val("rq_data", readdata2,                exp_w3);

        // Reset drops an in-flight read and ignores a request made during reset
        s2_issue(5'd5);
        reset = 1'b1;
        chipselect = 1'b1; read = 1'b1; address = 6'd5;
        tick();
        check_val("r6_vld2", {255'd0, readdatavalid2}, 256'd0);
        check_val("r6_rd2",  readdata2,                256'd0);
        check_val("r6_rd",   {128'd0, readdata},       256'd0);
        reset = 1'b0;
        idle();
        tick();
        check_val("r6_vld2_after", {255'd0, readdatavalid2}, 256'd0);
        check_val("r6_vld_after",  {255'd0, readdatavalid},  256'd0);
        s1_read(6'd5);
        check_val("r6_keep_vld", {255'd0, readdatavalid}, 256'd1);
        check_val("r6_keep",     {128'd0, readdata},      {128'd0, D1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
